// File: rtl/bus_defs.sv
// -----------------------------------------------------------------------------
// bus_defs
// Shared definitions for the two-master bus front end. The arbiter, its mux
// and the downstream address decoder use these definitions.
//   - arb_state_t : arbiter state encoding (IDLE / GNT0 / GNT1)
//   - owner_t     : identity of the master that most recently owned the bus
//   - ADDR_W_DEFAULT / DATA_W_DEFAULT : default master bus widths
//   - SLV*_SEL    : slave select codes that the decoder compares with M_addr[7:4]
// -----------------------------------------------------------------------------
package bus_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 32;

  // Slave address map: the decoder selects the slave from M_addr[7:4]
  localparam int         SLV_SEL_MSB = 7;
  localparam int         SLV_SEL_LSB = 4;
  localparam logic [3:0] SLV0_SEL    = 4'h0;
  localparam logic [3:0] SLV1_SEL    = 4'h1;
  localparam logic [3:0] SLV2_SEL    = 4'h2;
  localparam logic [3:0] SLV3_SEL    = 4'h3;

  // Grant state that hands the bus to the given master
  function automatic arb_state_t grant_state_of(input owner_t owner);
    arb_state_t st;
    case (owner)
      OWNER_M0: st = GNT0;
      OWNER_M1: st = GNT1;
      default:  st = IDLE;
    endcase
    return st;
  endfunction

  // Round-robin pick on contention: the master that did not own the bus last
  function automatic owner_t rr_winner(input owner_t last_owner);
    owner_t win;
    case (last_owner)
      OWNER_M0: win = OWNER_M1;
      OWNER_M1: win = OWNER_M0;
      default:  win = OWNER_M0;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/bus_mux2.sv
// -----------------------------------------------------------------------------
// bus_mux2
// 2:1 master-side bus multiplexer. It forwards master A when sel0 is high and
// master B when sel1 is high. When neither select is high (bus idle), it drives
// all outputs to zero. The arbiter guarantees that sel0 and sel1 are one-hot or
// both zero. If both are ever high, master A wins.
// Ports:
//   sel0, sel1                 : one-hot owner select from the arbiter state
//   a_req/a_wr/a_addr/a_dout   : master A request, write enable, address, data
//   b_req/b_wr/b_addr/b_dout   : master B request, write enable, address, data
//   y_req/y_wr/y_addr/y_dout   : muxed bus outputs (zeros when idle)
// -----------------------------------------------------------------------------
module bus_mux2 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              sel0,
  input  logic              sel1,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_dout,
  output logic              y_req,
  output logic              y_wr,
  output logic [ADDR_W-1:0] y_addr,
  output logic [DATA_W-1:0] y_dout
);

  // Select the owner's signals; drive zeros while no master owns the bus
  always_comb begin
    y_req  = 1'b0;
    y_wr   = 1'b0;
    y_addr = {ADDR_W{1'b0}};
    y_dout = {DATA_W{1'b0}};
    if (sel0) begin
      y_req  = a_req;
      y_wr   = a_wr;
      y_addr = a_addr;
      y_dout = a_dout;
    end else if (sel1) begin
      y_req  = b_req;
      y_wr   = b_wr;
      y_addr = b_addr;
      y_dout = b_dout;
    end else begin
      y_req  = 1'b0;
      y_wr   = 1'b0;
      y_addr = {ADDR_W{1'b0}};
      y_dout = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// Round-robin arbiter for two bus masters, plus the master-side mux that feeds
// the shared slave bus. The current owner keeps the grant for as long as it
// requests. If the other master is waiting, the arbiter forces a handover once
// the owner has held the bus for MAX_HOLD consecutive cycles.
// Parameters:
//   MAX_HOLD : maximum number of consecutive grant cycles under contention
//              (legal range 2..255)
//   ADDR_W   : master address width
//   DATA_W   : master write-data width
// Ports:
//   clk, reset                         : clock (rising edge); synchronous active-high reset
//   M0_req/M0_wr/M0_addr/M0_dout       : master 0 request, write enable, address, data
//   M1_req/M1_wr/M1_addr/M1_dout       : master 1 request, write enable, address, data
//   M0_grant, M1_grant                 : registered grants (never both high)
//   M_req/M_wr/M_addr/M_dout           : muxed owner signals (zeros when idle)
//   bus_busy                           : either grant is high
//   preempt                            : high in the first cycle after a forced handover
// -----------------------------------------------------------------------------
module bus_arbiter_rr
  import bus_defs::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_addr,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_addr,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  output logic              bus_busy,
  output logic              preempt
);

  // The hold counter saturates here. When the counter reaches this value and
  // the other master is waiting, the arbiter hands over the bus.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  arb_state_t state_r;
  arb_state_t next_state_s;
  logic [7:0] hold_cnt_r;
  owner_t     last_owner_r;
  logic       m0_grant_r;
  logic       m1_grant_r;
  logic       preempt_r;
  logic       preempt_s;
  logic       timeout_s;
  logic       sel0_s;
  logic       sel1_s;

  assign timeout_s = (hold_cnt_r == HOLD_LIMIT);

  // Next-state logic: round-robin on contention, hold while the owner requests,
  // and force a handover on timeout
  always_comb begin
    next_state_s = state_r;
    preempt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (M0_req && M1_req) begin
          next_state_s = grant_state_of(rr_winner(last_owner_r));
        end else if (M0_req) begin
          next_state_s = GNT0;
        end else if (M1_req) begin
          next_state_s = GNT1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GNT0: begin
        // A deassert takes priority over a timeout in the same cycle, so a
        // voluntary release never counts as a preemption
        if (!M0_req) begin
          if (M1_req) begin
            next_state_s = GNT1;
          end else begin
            next_state_s = IDLE;
          end
        end else if (timeout_s && M1_req) begin
          next_state_s = GNT1;
          preempt_s    = 1'b1;
        end else begin
          next_state_s = GNT0;
        end
      end
      GNT1: begin
        if (!M1_req) begin
          if (M0_req) begin
            next_state_s = GNT0;
          end else begin
            next_state_s = IDLE;
          end
        end else if (timeout_s && M0_req) begin
          next_state_s = GNT0;
          preempt_s    = 1'b1;
        end else begin
          next_state_s = GNT1;
        end
      end
      default: begin
        next_state_s = IDLE;
        preempt_s    = 1'b0;
      end
    endcase
  end

  // State, grant, preempt, hold-counter and last-owner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      m0_grant_r   <= 1'b0;
      m1_grant_r   <= 1'b0;
      preempt_r    <= 1'b0;
      hold_cnt_r   <= 8'd0;
      last_owner_r <= OWNER_M1;
    end else begin
      state_r    <= next_state_s;
      m0_grant_r <= (next_state_s == GNT0);
      m1_grant_r <= (next_state_s == GNT1);
      preempt_r  <= preempt_s;

      // A fresh grant, including a direct handover, restarts the hold count.
      // Idle cycles keep the counter at zero.
      if ((next_state_s == IDLE) || (next_state_s != state_r)) begin
        hold_cnt_r <= 8'd0;
      end else if (hold_cnt_r != HOLD_LIMIT) begin
        hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end

      if ((next_state_s != state_r) && (next_state_s == GNT0)) begin
        last_owner_r <= OWNER_M0;
      end else if ((next_state_s != state_r) && (next_state_s == GNT1)) begin
        last_owner_r <= OWNER_M1;
      end else begin
        last_owner_r <= last_owner_r;
      end
    end
  end

  assign sel0_s   = (state_r == GNT0);
  assign sel1_s   = (state_r == GNT1);
  assign M0_grant = m0_grant_r;
  assign M1_grant = m1_grant_r;
  assign bus_busy = m0_grant_r | m1_grant_r;
  assign preempt  = preempt_r;

  bus_mux2 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel0   (sel0_s),
    .sel1   (sel1_s),
    .a_req  (M0_req),
    .a_wr   (M0_wr),
    .a_addr (M0_addr),
    .a_dout (M0_dout),
    .b_req  (M1_req),
    .b_wr   (M1_wr),
    .b_addr (M1_addr),
    .b_dout (M1_dout),
    .y_req  (M_req),
    .y_wr   (M_wr),
    .y_addr (M_addr),
    .y_dout (M_dout)
  );

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
// Directed, table-driven bench for bus_arbiter_rr with MAX_HOLD = 8. The table
// lists expected grant and preempt values. The expected mux outputs follow
// from the expected owner and the inputs that the bench drives itself.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  logic        clk;
  logic        reset;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_addr, M1_addr;
  logic [31:0] M0_dout, M1_dout;
  logic        M0_grant, M1_grant, M_req, M_wr, bus_busy, preempt;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;

  int errors = 0;
  int checks = 0;

  bus_arbiter_rr #(
    .MAX_HOLD (8),
    .ADDR_W   (8),
    .DATA_W   (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .M0_req   (M0_req),
    .M0_wr    (M0_wr),
    .M0_addr  (M0_addr),
    .M0_dout  (M0_dout),
    .M1_req   (M1_req),
    .M1_wr    (M1_wr),
    .M1_addr  (M1_addr),
    .M1_dout  (M1_dout),
    .M0_grant (M0_grant),
    .M1_grant (M1_grant),
    .M_req    (M_req),
    .M_wr     (M_wr),
    .M_addr   (M_addr),
    .M_dout   (M_dout),
    .bus_busy (bus_busy),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic r0;
    logic w0;
    logic r1;
    logic w1;
    logic eg0;
    logic eg1;
    logic epre;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock edge and sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected owner and preempt value.
  // The expected mux outputs come from the currently driven inputs.
  task automatic exp_state(input string tag, input logic g0, input logic g1, input logic pre);
    logic        e_req, e_wr;
    logic [7:0]  e_addr;
    logic [31:0] e_dout;
    if (g0) begin
      e_req = M0_req; e_wr = M0_wr; e_addr = M0_addr; e_dout = M0_dout;
    end else if (g1) begin
      e_req = M1_req; e_wr = M1_wr; e_addr = M1_addr; e_dout = M1_dout;
    end else begin
      e_req = 1'b0; e_wr = 1'b0; e_addr = 8'h00; e_dout = 32'h0;
    end
    check({tag, "/M0_grant"}, 64'(M0_grant), 64'(g0));
    check({tag, "/M1_grant"}, 64'(M1_grant), 64'(g1));
    check({tag, "/bus_busy"}, 64'(bus_busy), 64'(g0 | g1));
    check({tag, "/preempt"},  64'(preempt),  64'(pre));
    check({tag, "/M_req"},    64'(M_req),    64'(e_req));
    check({tag, "/M_wr"},     64'(M_wr),     64'(e_wr));
    check({tag, "/M_addr"},   64'(M_addr),   64'(e_addr));
    check({tag, "/M_dout"},   64'(M_dout),   64'(e_dout));
  endtask

  initial begin
    int cnt;
    logic done;

    //          rst   r0    w0    r1    w1    eg0   eg1   epre
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // reset beats requests
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // M0 alone -> GNT0
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // hold
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // release -> IDLE, zeros
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // contention, last=M0 -> M1
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // M1 drops -> direct GNT0
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // IDLE
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // reset
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // both after reset -> M0
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // M0 drops -> GNT1, no gap
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // reset during GNT1
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // first contention -> M0
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // M1 alone
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset   = 1'b1;
    M0_req  = 1'b0; M0_wr = 1'b0; M0_addr = 8'h23; M0_dout = 32'h0;
    M1_req  = 1'b0; M1_wr = 1'b0; M1_addr = 8'h45; M1_dout = 32'h0;
    #1;

    for (int i = 0; i < 22; i++) begin
      reset   = vecs[i].rst;
      M0_req  = vecs[i].r0;
      M0_wr   = vecs[i].w0;
      M1_req  = vecs[i].r1;
      M1_wr   = vecs[i].w1;
      M0_dout = 32'hD000_0000 + 32'(i);
      M1_dout = 32'hE000_0000 + 32'(i);
      step();
      exp_state($sformatf("vec%0d", i), vecs[i].eg0, vecs[i].eg1, vecs[i].epre);
    end

    // Forced handover: M0 keeps requesting, and M1 starts requesting in M0's
    // second grant cycle. M0 must hold the bus for exactly 8 cycles.
    reset = 1'b0;
    M0_req = 1'b1; M0_wr = 1'b1; M1_req = 1'b0; M1_wr = 1'b0;
    M0_dout = 32'h1234_5678; M1_dout = 32'h8765_4321;
    step();
    exp_state("ph_g1", 1'b1, 1'b0, 1'b0);
    step();
    exp_state("ph_g2", 1'b1, 1'b0, 1'b0);
    M1_req = 1'b1;
    cnt  = 2;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (M0_grant) cnt++;
      else done = 1'b1;
    end
    check("ph_hold_len", 64'(cnt), 64'd8);
    exp_state("ph_handover", 1'b0, 1'b1, 1'b1);
    step();
    exp_state("ph_after", 1'b0, 1'b1, 1'b0);
    M0_req = 1'b0; M1_req = 1'b0;
    step();
    exp_state("ph_idle", 1'b0, 1'b0, 1'b0);

    // Saturation: M0 requests alone for 20 cycles and never gets preempted.
    // A saturated counter then lets a late M1 request win on the next edge.
    M0_req = 1'b1; M0_wr = 1'b0; M1_wr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      exp_state($sformatf("sat%0d", k), 1'b1, 1'b0, 1'b0);
    end
    M1_req = 1'b1;
    step();
    exp_state("sat_preempt", 1'b0, 1'b1, 1'b1);

    // M1 reaches hold count 7 and then releases while M0 waits: this is a
    // plain handover, so preempt stays low
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_state($sformatf("m1hold%0d", k), 1'b0, 1'b1, 1'b0);
    end
    M1_req = 1'b0;
    step();
    exp_state("deassert_at_to", 1'b1, 1'b0, 1'b0);

    // Same corner with M0 idle: the bus goes to IDLE and all muxed outputs are zero
    M0_req = 1'b0; M1_req = 1'b1;
    step();
    exp_state("m1_entry", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_state($sformatf("m1hold_b%0d", k), 1'b0, 1'b1, 1'b0);
    end
    M1_req = 1'b0; M0_wr = 1'b1; M1_wr = 1'b1;
    step();
    exp_state("deassert_idle", 1'b0, 1'b0, 1'b0);
    check("idle_addr_zero", 64'(M_addr), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
